// File: rtl/pixel_gen_axis.sv
// Test-pattern video source: 640x480 RGB888 frames packed 4 pixels per 3 AXI4-Stream
// words, with a small AXI4-Lite register file for pattern select and frame count.
module pixel_gen_axis #(
  parameter int X_SIZE = 480,
  parameter int Y_SIZE = 480,
  parameter int NREGS  = 8
) (
  input  logic        out_stream_aclk,
  input  logic        s_axi_lite_aclk,
  input  logic        axi_resetn,
  input  logic        periph_resetn,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid,
  output logic        out_stream_tuser,
  input  logic [7:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [7:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);
  localparam int AW = $clog2(NREGS);
  localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
  localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

  // Handshake rule on every channel: a beat moves on the rising edge where valid and
  // ready are both high; a raised valid and its payload stay put until that edge.

  // Packs pixels base..base+3 of line y into the word for the given phase.
  function automatic logic [31:0] pack_word(input logic [1:0] phase, input logic [15:0] base,
                                            input logic [15:0] y, input logic [7:0] blue);
    logic [23:0] p0, p1, p2, p3;
    logic [31:0] w;
    p0 = {base[7:0],         y[7:0], blue};
    p1 = {base[7:0] + 8'd1,  y[7:0], blue};
    p2 = {base[7:0] + 8'd2,  y[7:0], blue};
    p3 = {base[7:0] + 8'd3,  y[7:0], blue};
    case (phase)
      2'd0:    w = {p1[7:0], p0};
      2'd1:    w = {p2[15:0], p1[23:8]};
      default: w = {p3, p2[23:16]};
    endcase
    return w;
  endfunction

  logic [15:0] x_q, x_d, y_q, y_d, base_q, base_d;
  logic [1:0]  phase_q, phase_d;
  logic [31:0] frame_q, frame_d, tdata_q, tdata_d;
  logic [7:0]  blue_q, blue_d;
  logic        tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, load;

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic [31:0] rdata_q, rdata_d;
  logic        awready_q, awready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [AW-1:0] waddr, raddr;

  assign waddr = s_axi_lite_awaddr[2 +: AW];
  assign raddr = s_axi_lite_araddr[2 +: AW];

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    base_d   = base_q;
    phase_d  = phase_q;
    frame_d  = frame_q;
    blue_d   = blue_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    load     = 1'b0;
    if (!tvalid_q) begin
      // First edge out of reset: counters are already zero, only the colour is picked up.
      tvalid_d = 1'b1;
      blue_d   = regs_q[0][7:0];
      load     = 1'b1;
    end else if (out_stream_tready) begin
      load = 1'b1;
      if (x_q == X_LAST) begin
        x_d     = 16'd0;
        phase_d = 2'd0;
        base_d  = 16'd0;
        if (y_q == Y_LAST) begin
          y_d     = 16'd0;
          frame_d = frame_q + 32'd1;
          blue_d  = regs_q[0][7:0];
        end else begin
          y_d = y_q + 16'd1;
        end
      end else begin
        x_d = x_q + 16'd1;
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          base_d  = base_q + 16'd4;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
    end
    if (load) begin
      tdata_d = pack_word(phase_d, base_d, y_d, blue_d);
      tuser_d = (x_d == 16'd0) && (y_d == 16'd0);
      tlast_d = (x_d == X_LAST);
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      base_q   <= '0;
      phase_q  <= '0;
      frame_q  <= '0;
      blue_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      base_q   <= base_d;
      phase_q  <= phase_d;
      frame_q  <= frame_d;
      blue_q   <= blue_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  always_comb begin
    regs_d    = regs_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    awready_d = s_axi_lite_awvalid && s_axi_lite_wvalid && !bvalid_q && !awready_q;
    arready_d = s_axi_lite_arvalid && !rvalid_q && !arready_q;
    if (awready_q && s_axi_lite_awvalid && s_axi_lite_wvalid) begin
      if (waddr != AW'(1)) regs_d[waddr] = s_axi_lite_wdata;
      bvalid_d = 1'b1;
    end else if (bvalid_q && s_axi_lite_bready) begin
      bvalid_d = 1'b0;
    end
    if (arready_q && s_axi_lite_arvalid) begin
      rdata_d  = (raddr == AW'(1)) ? frame_q : regs_q[raddr];
      rvalid_d = 1'b1;
    end else if (rvalid_q && s_axi_lite_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign out_stream_tdata   = tdata_q;
  assign out_stream_tkeep   = 4'hF;
  assign out_stream_tlast   = tlast_q;
  assign out_stream_tvalid  = tvalid_q;
  assign out_stream_tuser   = tuser_q;
  assign s_axi_lite_awready = awready_q;
  assign s_axi_lite_wready  = awready_q;
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_arready = arready_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = 2'b00;
  assign s_axi_lite_rvalid  = rvalid_q;

  // The lite clock shares the stream clock net; low/high address bits are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_lite_aclk, s_axi_lite_awaddr[1:0], s_axi_lite_awaddr[7:2+AW],
                       s_axi_lite_araddr[1:0], s_axi_lite_araddr[7:2+AW]};
endmodule

// File: tb/tb_pixel_gen_axis.sv
// Directed bench for pixel_gen_axis: short frames (6 lines) keep the run small while the
// full 480-word line and the pixel byte stream are checked word by word.
module tb_pixel_gen_axis;
  localparam int XS = 480;
  localparam int YS = 6;

  logic        clk = 1'b0;
  logic        axi_resetn = 1'b1, periph_resetn = 1'b1;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tvalid, out_stream_tuser;
  logic        out_stream_tready = 1'b1;
  logic [7:0]  s_axi_lite_awaddr = '0, s_axi_lite_araddr = '0;
  logic        s_axi_lite_awvalid = 1'b0, s_axi_lite_wvalid = 1'b0, s_axi_lite_bready = 1'b0;
  logic        s_axi_lite_arvalid = 1'b0, s_axi_lite_rready = 1'b0;
  logic [31:0] s_axi_lite_wdata = '0;
  logic        s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bvalid;
  logic        s_axi_lite_arready, s_axi_lite_rvalid;
  logic [1:0]  s_axi_lite_bresp, s_axi_lite_rresp;
  logic [31:0] s_axi_lite_rdata;

  always #5 clk = ~clk;

  pixel_gen_axis #(.X_SIZE(XS), .Y_SIZE(YS), .NREGS(8)) dut (
    .out_stream_aclk(clk), .s_axi_lite_aclk(clk),
    .axi_resetn(axi_resetn), .periph_resetn(periph_resetn),
    .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
    .out_stream_tlast(out_stream_tlast), .out_stream_tready(out_stream_tready),
    .out_stream_tvalid(out_stream_tvalid), .out_stream_tuser(out_stream_tuser),
    .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awvalid(s_axi_lite_awvalid),
    .s_axi_lite_awready(s_axi_lite_awready), .s_axi_lite_wdata(s_axi_lite_wdata),
    .s_axi_lite_wvalid(s_axi_lite_wvalid), .s_axi_lite_wready(s_axi_lite_wready),
    .s_axi_lite_bresp(s_axi_lite_bresp), .s_axi_lite_bvalid(s_axi_lite_bvalid),
    .s_axi_lite_bready(s_axi_lite_bready), .s_axi_lite_araddr(s_axi_lite_araddr),
    .s_axi_lite_arvalid(s_axi_lite_arvalid), .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
    .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready)
  );

  int          n_assert = 0, n_fail = 0;
  bit          rand_mode = 1'b0, exp_valid = 1'b0;
  int          ex = 0, ey = 0, tlast_cnt = 0;
  logic [7:0]  eblue = '0;
  logic [31:0] eframe = '0, reg0_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Line byte stream: pixel px occupies bytes 3px..3px+2 as B, G, R; word w is bytes 4w..4w+3.
  function automatic logic [31:0] exp_word(input int x, input int y, input logic [7:0] blue);
    logic [31:0] w;
    int b, px;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      b  = 4 * x + i;
      px = b / 3;
      case (b % 3)
        0:       w[8*i +: 8] = blue;
        1:       w[8*i +: 8] = 8'(y);
        default: w[8*i +: 8] = 8'(px);
      endcase
    end
    return w;
  endfunction

  task automatic check_stream();
    if (exp_valid) begin
      chk("tvalid", 32'(out_stream_tvalid), 32'd1);
      chk("tdata", out_stream_tdata, exp_word(ex, ey, eblue));
      chk("tuser", 32'(out_stream_tuser), 32'((ex == 0) && (ey == 0)));
      chk("tlast", 32'(out_stream_tlast), 32'(ex == XS - 1));
      chk("tkeep", 32'(out_stream_tkeep), 32'hF);
    end else begin
      chk("idle_tvalid", 32'(out_stream_tvalid), 32'd0);
      chk("idle_tdata", out_stream_tdata, 32'd0);
      chk("idle_tuser", 32'(out_stream_tuser), 32'd0);
      chk("idle_tlast", 32'(out_stream_tlast), 32'd0);
    end
  endtask

  // One clock: pick tready, step the model on a transfer, then check the presented word.
  task automatic cycle();
    logic rdy, rst_edge, was_tlast;
    rdy = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    out_stream_tready = rdy;
    rst_edge  = periph_resetn;
    was_tlast = out_stream_tvalid && out_stream_tlast;
    @(posedge clk);
    #1;
    if (exp_valid && rdy) begin
      if (was_tlast) tlast_cnt++;
      if (ex == XS - 1) begin
        ex = 0;
        if (ey == YS - 1) begin
          ey     = 0;
          eframe = eframe + 32'd1;
          eblue  = reg0_m[7:0];
        end else begin
          ey++;
        end
      end else begin
        ex++;
      end
    end else if (!exp_valid && rst_edge) begin
      exp_valid = 1'b1;
      eblue     = reg0_m[7:0];
    end
    check_stream();
  endtask

  task automatic run_to_frame(input logic [31:0] target);
    for (int k = 0; k < 4 * XS * YS && eframe != target; k++) cycle();
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
    int k;
    s_axi_lite_awaddr  = addr;
    s_axi_lite_wdata   = data;
    s_axi_lite_awvalid = 1'b1;
    s_axi_lite_wvalid  = 1'b1;
    s_axi_lite_bready  = 1'b0;
    k = 0;
    while (!s_axi_lite_awready && k < 20) begin cycle(); k++; end
    chk("awready_seen", 32'(s_axi_lite_awready), 32'd1);
    chk("wready_with_aw", 32'(s_axi_lite_wready), 32'd1);
    cycle();
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wvalid  = 1'b0;
    if (addr[4:2] == 3'd0) reg0_m = data;
    chk("awready_pulse", 32'(s_axi_lite_awready), 32'd0);
    chk("bvalid_rise", 32'(s_axi_lite_bvalid), 32'd1);
    chk("bresp", 32'(s_axi_lite_bresp), 32'd0);
    repeat (2) cycle();
    chk("bvalid_hold", 32'(s_axi_lite_bvalid), 32'd1);
    s_axi_lite_bready = 1'b1;
    cycle();
    s_axi_lite_bready = 1'b0;
    chk("bvalid_clear", 32'(s_axi_lite_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    int k;
    s_axi_lite_araddr  = addr;
    s_axi_lite_arvalid = 1'b1;
    s_axi_lite_rready  = 1'b0;
    k = 0;
    while (!s_axi_lite_arready && k < 20) begin cycle(); k++; end
    chk({"arready_seen ", tag}, 32'(s_axi_lite_arready), 32'd1);
    cycle();
    s_axi_lite_arvalid = 1'b0;
    chk({"rvalid_rise ", tag}, 32'(s_axi_lite_rvalid), 32'd1);
    chk({"rdata ", tag}, s_axi_lite_rdata, exp);
    chk({"rresp ", tag}, 32'(s_axi_lite_rresp), 32'd0);
    cycle();
    chk({"rvalid_hold ", tag}, 32'(s_axi_lite_rvalid), 32'd1);
    s_axi_lite_rready = 1'b1;
    cycle();
    s_axi_lite_rready = 1'b0;
    chk({"rvalid_clear ", tag}, 32'(s_axi_lite_rvalid), 32'd0);
  endtask

  initial begin
    #2;
    axi_resetn    = 1'b0;
    periph_resetn = 1'b0;
    repeat (3) cycle();
    chk("rst_awready", 32'(s_axi_lite_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_lite_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_lite_bvalid), 32'd0);
    chk("rst_arready", 32'(s_axi_lite_arready), 32'd0);
    chk("rst_rvalid", 32'(s_axi_lite_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_lite_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_lite_rresp), 32'd0);
    chk("rst_rdata", s_axi_lite_rdata, 32'd0);

    axi_resetn    = 1'b1;
    periph_resetn = 1'b1;
    tlast_cnt     = 0;
    cycle();
    chk("first_tvalid", 32'(out_stream_tvalid), 32'd1);
    chk("first_tuser", 32'(out_stream_tuser), 32'd1);
    chk("first_word", out_stream_tdata, 32'h0000_0000);
    cycle();
    chk("word1", out_stream_tdata, 32'h0000_0100);
    cycle();
    chk("word2", out_stream_tdata, 32'h0300_0002);

    repeat (300) cycle();
    axi_write(8'h00, 32'h0000_0055);
    axi_write(8'h08, 32'hDEAD_BEEF);
    axi_read(8'h08, 32'hDEAD_BEEF, "reg2");
    axi_read(8'hAB, 32'hDEAD_BEEF, "reg2_alias");
    axi_write(8'h04, 32'h1234_5678);
    axi_read(8'h04, 32'd0, "frame_cnt0");
    axi_read(8'h00, 32'h0000_0055, "reg0");

    run_to_frame(32'd1);
    chk("f0_tlast_count", 32'(tlast_cnt), 32'(YS));
    chk("f1_tuser", 32'(out_stream_tuser), 32'd1);
    chk("f1_word0", out_stream_tdata, 32'h5500_0055);
    axi_read(8'h04, 32'd1, "frame_cnt1");

    tlast_cnt = 0;
    rand_mode = 1'b1;
    run_to_frame(32'd2);
    rand_mode = 1'b0;
    chk("f1_tlast_count", 32'(tlast_cnt), 32'(YS));

    repeat (100) cycle();
    periph_resetn = 1'b0;
    exp_valid     = 1'b0;
    ex            = 0;
    ey            = 0;
    eframe        = '0;
    #1;
    chk("midrst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("midrst_tdata", out_stream_tdata, 32'd0);
    chk("midrst_tuser", 32'(out_stream_tuser), 32'd0);
    chk("midrst_tlast", 32'(out_stream_tlast), 32'd0);
    repeat (2) cycle();
    periph_resetn = 1'b1;
    cycle();
    chk("rel_tuser", 32'(out_stream_tuser), 32'd1);
    chk("rel_word0", out_stream_tdata, 32'h5500_0055);
    axi_read(8'h04, 32'd0, "frame_cnt_rst");
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_gen_axis.md
Name: pixel_gen_axis

Overview:
- Test-pattern video source for the display path.
- Streams 640x480 RGB888 frames as packed 32-bit AXI4-Stream words: 4 pixels in 3 words, 480 words per line, 480 lines.
- Marks start-of-frame on tuser and end-of-line on tlast.
- Small AXI4-Lite register file sets the pattern and reports the frame count.

Parameters:
- X_SIZE, 480, words per line (pixels*3/4).
- Y_SIZE, 480, lines per frame.
- NREGS, 8, number of 32-bit AXI-Lite registers (address bits [4:2]).

Ports:
- out_stream_aclk  in  1  the single clock; all logic clocked here.
- s_axi_lite_aclk  in  1  must be driven from the same net as out_stream_aclk; not used internally.
- axi_resetn  in  1  asynchronous active-low reset for the AXI-Lite register file.
- periph_resetn  in  1  asynchronous active-low reset for the pixel/stream logic.
- out_stream_tdata  out  32  packed pixel word.
- out_stream_tkeep  out  4  always 4'hF.
- out_stream_tlast  out  1  last word of a line.
- out_stream_tready  in  1  downstream ready.
- out_stream_tvalid  out  1  word valid.
- out_stream_tuser  out  1  first word of a frame.
- s_axi_lite_awaddr  in  8;  s_axi_lite_awvalid  in  1;  s_axi_lite_awready  out  1.
- s_axi_lite_wdata  in  32;  s_axi_lite_wvalid  in  1;  s_axi_lite_wready  out  1.
- s_axi_lite_bresp  out  2;  s_axi_lite_bvalid  out  1;  s_axi_lite_bready  in  1.
- s_axi_lite_araddr  in  8;  s_axi_lite_arvalid  in  1;  s_axi_lite_arready  out  1.
- s_axi_lite_rdata  out  32;  s_axi_lite_rresp  out  2;  s_axi_lite_rvalid  out  1;  s_axi_lite_rready  in  1.

Behaviour:
- Reset, periph_resetn low:
  - Counters x_word=0, y=0, frame=0; tvalid=0, tuser=0, tlast=0, tdata=0.
  - Asynchronous assert, synchronous release.
- Reset, axi_resetn low:
  - All registers 0; all AXI-Lite ready/valid outputs 0; bresp=rresp=2'b00.
- Stream:
  - tvalid goes high on the first clock edge after periph_resetn release.
  - tvalid then stays high permanently; the source never stalls. Frames repeat back-to-back.
  - Word transfers when tvalid&&tready. While tvalid&&!tready, tdata/tuser/tlast stay stable.
  - On transfer, x_word increments. At x_word==X_SIZE-1 it wraps to 0 and y increments.
  - At y==Y_SIZE-1 with the last word, y wraps to 0, frame increments (32-bit wrap), and reg0 is latched into blue_l.
- Framing flags:
  - tuser=1 only when x_word==0 && y==0.
  - tlast=1 only when x_word==X_SIZE-1.
- Pixel pattern, pixel (px, y), px 0..639:
  - R = px[7:0], G = y[7:0], B = blue_l[7:0].
  - Pixel word p = {R,G,B} (24 bits).
- Packing: group g = x_word/3 covers pixels p0..p3 = px 4g..4g+3. By phase x_word%3:
  - 0: {p1[7:0], p0[23:0]}
  - 1: {p2[15:0], p1[23:8]}
  - 2: {p3[23:0], p2[23:16]}
- Pattern-select timing: blue_l is loaded from reg0 at reset release and at each frame boundary. A mid-frame write to reg0 takes effect on the next frame only.
- AXI-Lite write:
  - awready and wready pulse high together for one cycle when awvalid&&wvalid&&!bvalid.
  - Register awaddr[4:2] gets wdata, except reg1, which is read-only and whose writes are ignored.
  - bvalid then rises with bresp=OKAY and holds until bready.
- AXI-Lite read:
  - arready pulses one cycle when arvalid&&!rvalid.
  - rdata is registered, rresp=OKAY; rvalid holds until rready.
  - Reg1 reads the frame count; other registers read back their stored value.
  - Address bits [1:0] and [7:5] are ignored.
- Simultaneous read and write are served independently in the same cycle.

Test Plan:
- Reset, tready=1, reg0=0: first word after release is tvalid=1, tuser=1, tdata=0x00000000. Next words are 0x00000100, then 0x03000002.
- tready=1 for 480*480 cycles: tlast exactly on every 480th word. Exactly 480 tlast pulses, then tuser on the next word. Frame count (reg1) reads 1.
- Pseudo-random tready (50%): no tuser/tlast misplacement. tdata held stable across every stall. tvalid never low after the first cycle.
- Write reg0=0x55 mid-frame 0: frame 0 unchanged. Frame 1 first word = 0x55000055.
- AXI-Lite: write 0xDEADBEEF to addr 0x08, read back 0xDEADBEEF with rresp=0. A write to addr 0x04 is ignored (reads frame count). bvalid held until bready.
- Assert periph_resetn low mid-line: outputs clear immediately. After release, the next word carries tuser=1 with tdata=word0 of a new frame.
